// File: rtl/mask_sel_decode.sv
// Converts a (start, length) bit-field request into the four half-mask selects
// for the two-half logic-immediate mask generator, through a 2-stage handshake pipeline.
module mask_sel_decode #(
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          in_start,
    input  logic [6:0]          in_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          LowMaskSel_Bot,
    output logic [4:0]          HighMaskSel_Bot,
    output logic [4:0]          LowMaskSel_Top,
    output logic [4:0]          HighMaskSel_Top,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic                s1Valid_q, s1Valid_d;
    logic [5:0]          s1Start_q, s1Start_d;
    logic [6:0]          s1Len_q, s1Len_d;
    logic                s1Err_q, s1Err_d;
    logic                outValid_q, outValid_d;
    logic [4:0]          lowBot_q, lowBot_d;
    logic [4:0]          highBot_q, highBot_d;
    logic [4:0]          lowTop_q, lowTop_d;
    logic [4:0]          highTop_q, highTop_d;
    logic                outErr_q, outErr_d;
    logic [ERRCNT_W-1:0] errCount_q, errCount_d;

    logic       inReady;
    logic       accept;
    logic       s2Load;
    logic [7:0] inSum;
    logic       inErr;
    logic [7:0] s1End;

    always_comb begin
        inReady = !s1Valid_q || !outValid_q || out_ready;
        accept  = in_valid && inReady;
        s2Load  = s1Valid_q && (!outValid_q || out_ready);

        // 8-bit sum so that start+len can never wrap back into the legal range
        inSum = {2'b00, in_start} + {1'b0, in_len};
        inErr = (in_len == 7'd0) || (inSum > 8'd64);
        s1End = {2'b00, s1Start_q} + {1'b0, s1Len_q} - 8'd1;

        s1Valid_d  = s1Valid_q;
        s1Start_d  = s1Start_q;
        s1Len_d    = s1Len_q;
        s1Err_d    = s1Err_q;
        outValid_d = outValid_q;
        lowBot_d   = lowBot_q;
        highBot_d  = highBot_q;
        lowTop_d   = lowTop_q;
        highTop_d  = highTop_q;
        outErr_d   = outErr_q;
        errCount_d = errCount_q;

        if (accept) begin
            s1Valid_d = 1'b1;
            s1Start_d = in_start;
            s1Len_d   = in_len;
            s1Err_d   = inErr;
            if (inErr && (errCount_q != {ERRCNT_W{1'b1}})) begin
                errCount_d = errCount_q + ERRCNT_W'(1);
            end
        end else if (s2Load) begin
            s1Valid_d = 1'b0;
        end

        if (s2Load) begin
            outValid_d = 1'b1;
            outErr_d   = s1Err_q;
            lowBot_d   = 5'd31;
            highBot_d  = 5'd0;
            lowTop_d   = 5'd31;
            highTop_d  = 5'd0;
            // A legal field ends at or below bit 63, so s1End[5] means "reaches the top half"
            if (!s1Err_q && !s1Start_q[5]) begin
                lowBot_d  = s1Start_q[4:0];
                highBot_d = (s1End >= 8'd31) ? 5'd31 : s1End[4:0];
            end
            if (!s1Err_q && s1End[5]) begin
                lowTop_d  = s1Start_q[5] ? s1Start_q[4:0] : 5'd0;
                highTop_d = s1End[4:0];
            end
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q  <= 1'b0;
            s1Start_q  <= 6'd0;
            s1Len_q    <= 7'd0;
            s1Err_q    <= 1'b0;
            outValid_q <= 1'b0;
            lowBot_q   <= 5'd31;
            highBot_q  <= 5'd0;
            lowTop_q   <= 5'd31;
            highTop_q  <= 5'd0;
            outErr_q   <= 1'b0;
            errCount_q <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Start_q  <= s1Start_d;
            s1Len_q    <= s1Len_d;
            s1Err_q    <= s1Err_d;
            outValid_q <= outValid_d;
            lowBot_q   <= lowBot_d;
            highBot_q  <= highBot_d;
            lowTop_q   <= lowTop_d;
            highTop_q  <= highTop_d;
            outErr_q   <= outErr_d;
            errCount_q <= errCount_d;
        end
    end

    assign in_ready        = inReady;
    assign out_valid       = outValid_q;
    assign LowMaskSel_Bot  = lowBot_q;
    assign HighMaskSel_Bot = highBot_q;
    assign LowMaskSel_Top  = lowTop_q;
    assign HighMaskSel_Top = highTop_q;
    assign out_err         = outErr_q;
    assign err_count       = errCount_q;

endmodule

// File: tb/tb_mask_sel_decode.sv
// Randomized and directed bench for mask_sel_decode; expected selects come from
// building the literal 64-bit mask and locating its lowest/highest one per half.
module tb_mask_sel_decode;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_start = '0;
    logic [6:0] in_len = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] LowMaskSel_Bot, HighMaskSel_Bot, LowMaskSel_Top, HighMaskSel_Top;
    logic       out_err;
    logic [7:0] err_count;

    int numChecks = 0;
    int numFails  = 0;
    int cyc       = 0;
    int expErrCnt = 0;

    typedef struct {
        int         acc;
        logic [4:0] lb, hb, lt, ht;
        logic       err;
    } exp_t;

    exp_t q[$];

    mask_sel_decode #(.ERRCNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_start(in_start), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .LowMaskSel_Bot(LowMaskSel_Bot), .HighMaskSel_Bot(HighMaskSel_Bot),
        .LowMaskSel_Top(LowMaskSel_Top), .HighMaskSel_Top(HighMaskSel_Top),
        .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    // Lowest and highest set bit of one 32-bit half; an empty half encodes as 31/0
    function automatic logic [9:0] halfSel(input logic [31:0] h);
        int lo = 31;
        int hi = 0;
        bit found = 0;
        for (int b = 0; b < 32; b++) begin
            if (h[b]) begin
                if (!found) lo = b;
                hi = b;
                found = 1;
            end
        end
        return {5'(lo), 5'(hi)};
    endfunction

    function automatic exp_t refModel(input int s, input int l, input int acc);
        exp_t e;
        logic [63:0] m = '0;
        logic [9:0] bot, top;
        e.err = (l == 0) || (s + l > 64);
        if (!e.err)
            for (int b = s; b < s + l; b++) m[b] = 1'b1;
        bot = halfSel(m[31:0]);
        top = halfSel(m[63:32]);
        e.lb = bot[9:5]; e.hb = bot[4:0];
        e.lt = top[9:5]; e.ht = top[4:0];
        e.acc = acc;
        return e;
    endfunction

    // One clock: drive at negedge, check and record handshakes before the next posedge
    task automatic applyStimulus(input logic v, input int s, input int l, input logic r);
        logic accept, fire, expValid;
        @(negedge clk);
        in_valid = v; in_start = 6'(s); in_len = 7'(l); out_ready = r;
        #1;
        expValid = (q.size() > 0) && (q[0].acc + 2 <= cyc);
        checkOutput("in_ready", 32'(in_ready), 32'((q.size() < 2) || r));
        checkOutput("out_valid", 32'(out_valid), 32'(expValid));
        checkOutput("err_count", 32'(err_count), 32'(expErrCnt));
        if (out_valid && q.size() > 0) begin
            checkOutput("LowBot", 32'(LowMaskSel_Bot), 32'(q[0].lb));
            checkOutput("HighBot", 32'(HighMaskSel_Bot), 32'(q[0].hb));
            checkOutput("LowTop", 32'(LowMaskSel_Top), 32'(q[0].lt));
            checkOutput("HighTop", 32'(HighMaskSel_Top), 32'(q[0].ht));
            checkOutput("out_err", 32'(out_err), 32'(q[0].err));
        end
        accept = v && in_ready;
        fire   = out_valid && r;
        if (fire && q.size() > 0) void'(q.pop_front());
        if (accept) begin
            exp_t e = refModel(s, l, cyc);
            q.push_back(e);
            if (e.err && expErrCnt < 255) expErrCnt++;
        end
        cyc++;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_LowBot", 32'(LowMaskSel_Bot), 32'd31);
        checkOutput("rst_HighBot", 32'(HighMaskSel_Bot), 32'd0);
        checkOutput("rst_LowTop", 32'(LowMaskSel_Top), 32'd31);
        checkOutput("rst_HighTop", 32'(HighMaskSel_Top), 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        q.delete();
        expErrCnt = 0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        doReset();

        // Directed: full mask, straddling field, top-only field, two illegal requests
        applyStimulus(1, 0, 64, 1);
        applyStimulus(1, 28, 8, 1);
        applyStimulus(1, 40, 4, 1);
        applyStimulus(1, 60, 5, 1);
        applyStimulus(1, 10, 0, 1);
        applyStimulus(1, 31, 1, 1);
        applyStimulus(1, 32, 32, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

        // Backpressure: three back-to-back requests while downstream stalls
        applyStimulus(1, 5, 10, 0);
        applyStimulus(1, 20, 30, 0);
        applyStimulus(1, 63, 1, 0);
        applyStimulus(1, 63, 1, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);

        // Reset with requests in flight, then confirm nothing stale emerges
        applyStimulus(1, 1, 2, 0);
        applyStimulus(1, 50, 70, 0);
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

        for (int i = 0; i < 2000; i++) begin
            int s = int'($urandom_range(0, 63));
            int l;
            case ($urandom_range(0, 9))
                0:       l = 0;
                1:       l = int'($urandom_range(65, 127));
                2:       l = 64 - s;
                default: l = int'($urandom_range(1, 64));
            endcase
            applyStimulus(logic'($urandom_range(0, 3) != 0), s, l, logic'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

        // Saturation of the illegal-request counter
        doReset();
        for (int i = 0; i < 300; i++) applyStimulus(1, 60, 5, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("err_count_sat", 32'(err_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
